// File: rtl/eddsa_pkg.sv
// -----------------------------------------------------------------------------
// eddsa_pkg
// Constants and encodings shared by the EdDSA25519 accelerator arithmetic blocks.
//   P            : field prime 2^255 - 19
//   arb_state_t  : add/sub arbiter FSM state encoding
//   ADD / SUB    : add_sub operation mode encodings
// -----------------------------------------------------------------------------
package eddsa_pkg;

    localparam logic [255:0] P =
        256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/add_sub.sv
// -----------------------------------------------------------------------------
// add_sub
// Mod-p adder/subtractor with one register stage. The unreduced sum/difference
// is registered into c_0_reg; the final conditional subtraction of p is
// combinational, so c is valid the cycle after the operands are presented.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   mode     : ADD (0) or SUB (1)
//   a, b     : operands, expected reduced (< p)
//   c        : (a +/- b) mod p, valid one cycle after a/b/mode
// -----------------------------------------------------------------------------
module add_sub
    import eddsa_pkg::*;
#(
    parameter int BIT_LENGTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [BIT_LENGTH-1:0] a,
    input  logic [BIT_LENGTH-1:0] b,
    output logic [BIT_LENGTH-1:0] c
);

    localparam int EXT_W = BIT_LENGTH + 1;
    localparam logic [BIT_LENGTH:0] P_EXT = EXT_W'(P);

    logic [BIT_LENGTH:0] c_0_next;
    logic [BIT_LENGTH:0] c_0_reg;
    logic [BIT_LENGTH:0] c_red;

    // Raw result is always < 2p, so one conditional subtraction fully reduces
    // it. A borrowing subtraction produces p - (b - a), which equals p when
    // a == b and is then reduced to 0 by the same step.
    always_comb begin
        c_0_next = '0;
        if (mode == SUB) begin
            if (a > b) begin
                c_0_next = {1'b0, a - b};
            end else begin
                c_0_next = P_EXT - {1'b0, b - a};
            end
        end else begin
            c_0_next = {1'b0, a} + {1'b0, b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_0_reg <= '0;
        end else begin
            c_0_reg <= c_0_next;
        end
    end

    assign c_red = c_0_reg - P_EXT;
    assign c     = (c_0_reg >= P_EXT) ? c_red[BIT_LENGTH-1:0] : c_0_reg[BIT_LENGTH-1:0];

endmodule

// File: rtl/rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Combinational priority select. The search starts at ptr and wraps from
// NREQ-1 back to 0; the first valid requester found wins.
// Ports:
//   req_valid : per-requester request strobes
//   ptr       : index with highest priority (tie to 0 for fixed priority)
//   grant     : one-hot winner (all zero when no request)
//   idx       : binary index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module rr_grant #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    always_comb begin : select
        int               j;
        logic [IDX_W-1:0] j_idx;
        logic             found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        j_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            j_idx = IDX_W'(j);
            if (!found && req_valid[j_idx]) begin
                found        = 1'b1;
                grant[j_idx] = 1'b1;
                idx          = j_idx;
            end
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_arbiter
// Shares one mod-p add_sub unit among NREQ requesters. One operation is in
// flight at a time: IDLE (grant) -> EXEC -> CAPT -> RESP -> IDLE, i.e. one
// operation every four cycles, response three cycles after the handshake.
// Build option:
//   ADDSUB_ARB_RR_EN defined   : round-robin priority, pointer moves to
//                                (winner + 1) mod NREQ on each handshake
//   ADDSUB_ARB_RR_EN undefined : fixed priority, lowest index wins
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester request strobe (held until handshake)
//   req_ready  : one-hot grant, only in IDLE
//   req_mode   : per-requester op, 0 add / 1 sub
//   req_a/b    : packed operands, requester i at [i*BIT_LENGTH +: BIT_LENGTH]
//   rsp_valid  : one-hot single-cycle response pulse to the owner
//   rsp_data   : (A +/- B) mod p, held until the next capture
//   busy       : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module addsub_arbiter
    import eddsa_pkg::*;
#(
    parameter int BIT_LENGTH = 256,
    parameter int NREQ       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            req_mode,
    input  logic [NREQ*BIT_LENGTH-1:0] req_a,
    input  logic [NREQ*BIT_LENGTH-1:0] req_b,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [BIT_LENGTH-1:0]      rsp_data,
    output logic                       busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t            state_reg;
    logic [BIT_LENGTH-1:0] op_a_reg;
    logic [BIT_LENGTH-1:0] op_b_reg;
    logic                  op_mode_reg;
    logic [IDX_W-1:0]      owner_reg;
    logic [NREQ-1:0]       rsp_valid_reg;
    logic [BIT_LENGTH-1:0] rsp_data_reg;
    logic                  busy_reg;

    logic [BIT_LENGTH-1:0] a_arr [NREQ];
    logic [BIT_LENGTH-1:0] b_arr [NREQ];
    logic [NREQ-1:0]       grant;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      ptr;
    logic [NREQ-1:0]       owner_onehot;
    logic [BIT_LENGTH-1:0] add_c;
    logic                  handshake;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*BIT_LENGTH +: BIT_LENGTH];
            assign b_arr[gi] = req_b[gi*BIT_LENGTH +: BIT_LENGTH];
        end
    endgenerate

    rr_grant #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_grant (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .idx       (win_idx)
    );

    // rr_grant always picks someone when any request is present, so a pending
    // request in IDLE is always a handshake.
    assign handshake = (state_reg == IDLE) && (|req_valid);

`ifdef ADDSUB_ARB_RR_EN
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;

    always_comb begin
        ptr_next = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (handshake) begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;
`else
    assign ptr = '0;
`endif

    add_sub #(
        .BIT_LENGTH (BIT_LENGTH)
    ) u_add_sub (
        .clk  (clk),
        .rst  (rst),
        .mode (op_mode_reg),
        .a    (op_a_reg),
        .b    (op_b_reg),
        .c    (add_c)
    );

    assign owner_onehot = NREQ'(1) << owner_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            op_mode_reg   <= ADD;
            owner_reg     <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            busy_reg      <= 1'b0;
        end else begin
            rsp_valid_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        op_a_reg    <= a_arr[win_idx];
                        op_b_reg    <= b_arr[win_idx];
                        op_mode_reg <= req_mode[win_idx];
                        owner_reg   <= win_idx;
                        busy_reg    <= 1'b1;
                        state_reg   <= EXEC;
                    end
                end
                EXEC: begin
                    // add_sub latches its raw result at the end of this cycle
                    state_reg <= CAPT;
                end
                CAPT: begin
                    rsp_data_reg  <= add_c;
                    rsp_valid_reg <= owner_onehot;
                    state_reg     <= RESP;
                end
                RESP: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_reg == IDLE) ? grant : '0;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign busy      = busy_reg;

endmodule
